// File: rtl/ysyx_24100005_pkg.sv
// Shared LSU definitions: RISC-V load/store funct3 codes, FSM state type, access-size decode.
package ysyx_24100005_pkg;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LD  = 3'd3;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_LWU = 3'd6;

    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;
    localparam logic [2:0] F3_SD  = 3'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MREQ  = 2'd1,
        ST_MWAIT = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_e;

    // Access size in bytes (1, 2, 4, 8) from the low funct3 bits.
    function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
        size_bytes = 4'd1 << funct3[1:0];
    endfunction

endpackage

// File: rtl/ysyx_24100005_lsu_align.sv
// LSU lane logic: address alignment, store shift/mask, load shift/extension, access legality.
// Optional macro YSYX_24100005_LSU_MISALIGN_EN turns misaligned accesses into faults.
module ysyx_24100005_lsu_align
    import ysyx_24100005_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 32
) (
    input  logic                         req_we_i,
    input  logic [2:0]                   req_funct3_i,
    input  logic [ADDR_W-1:0]            req_addr_i,
    input  logic [XLEN-1:0]              req_wdata_i,
    output logic                         fault_c,
    output logic [ADDR_W-1:0]            mem_addr_c,
    output logic [XLEN-1:0]              mem_wdata_c,
    output logic [XLEN/8-1:0]            mem_wmask_c,
    input  logic [2:0]                   ld_funct3_i,
    input  logic [$clog2(XLEN/8)-1:0]    ld_off_i,
    input  logic [XLEN-1:0]              ld_rdata_i,
    output logic [XLEN-1:0]              ld_data_c
);

    localparam int unsigned NB    = XLEN / 8;
    localparam int unsigned OFF_W = $clog2(NB);

    logic [OFF_W-1:0] st_off;
    logic [3:0]       st_size;
    logic             legal;
    logic [XLEN-1:0]  ld_shifted;

    assign st_off      = req_addr_i[OFF_W-1:0];
    assign st_size     = size_bytes(req_funct3_i);
    assign mem_addr_c  = {req_addr_i[ADDR_W-1:OFF_W], OFF_W'(0)};
    assign mem_wdata_c = req_wdata_i << {st_off, 3'b000};
    // Full-word accesses wrap 1<<NB to zero, so the subtraction yields all ones.
    assign mem_wmask_c = ((NB'(1) << st_size) - NB'(1)) << st_off;

    // Legal funct3 codes depend on direction and on XLEN.
    always_comb begin
        legal = 1'b0;
        if (req_we_i) begin
            case (req_funct3_i)
                F3_SB, F3_SH, F3_SW: legal = 1'b1;
                F3_SD:               legal = (XLEN == 64);
                default:             legal = 1'b0;
            endcase
        end else begin
            case (req_funct3_i)
                F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: legal = 1'b1;
                F3_LD, F3_LWU:                       legal = (XLEN == 64);
                default:                             legal = 1'b0;
            endcase
        end
    end

`ifdef YSYX_24100005_LSU_MISALIGN_EN
    assign fault_c = !legal || ((st_off & OFF_W'(st_size - 4'd1)) != '0);
`else
    assign fault_c = !legal;
`endif

    assign ld_shifted = ld_rdata_i >> {ld_off_i, 3'b000};

    // Sign/zero extension of the shifted load lane.
    always_comb begin
        ld_data_c = ld_shifted;
        case (ld_funct3_i)
            F3_LB:   ld_data_c = XLEN'($signed(ld_shifted[7:0]));
            F3_LH:   ld_data_c = XLEN'($signed(ld_shifted[15:0]));
            F3_LW:   ld_data_c = XLEN'($signed(ld_shifted[31:0]));
            F3_LBU:  ld_data_c = XLEN'(ld_shifted[7:0]);
            F3_LHU:  ld_data_c = XLEN'(ld_shifted[15:0]);
            F3_LWU:  ld_data_c = XLEN'(ld_shifted[31:0]);
            default: ld_data_c = ld_shifted;
        endcase
    end

endmodule

// File: rtl/ysyx_24100005_lsu.sv
// Load/store unit: single outstanding access, IDLE -> MREQ -> MWAIT -> RESP, registered outputs.
// Optional macro YSYX_24100005_LSU_MISALIGN_EN faults misaligned accesses without a memory request.
module ysyx_24100005_lsu
    import ysyx_24100005_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [2:0]           req_funct3,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [XLEN-1:0]      req_wdata,
    output logic                 rsp_valid,
    output logic [XLEN-1:0]      rsp_rdata,
    output logic                 rsp_err,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic                 mem_we,
    output logic [XLEN-1:0]      mem_wdata,
    output logic [XLEN/8-1:0]    mem_wmask,
    input  logic                 mem_rsp_valid,
    input  logic [XLEN-1:0]      mem_rdata
);

    localparam int unsigned NB    = XLEN / 8;
    localparam int unsigned OFF_W = $clog2(NB);

    lsu_state_e          state_q, state_d;
    logic                we_q, we_d;
    logic [2:0]          funct3_q, funct3_d;
    logic [OFF_W-1:0]    off_q, off_d;
    logic                req_ready_q, req_ready_d;
    logic                mem_req_valid_q, mem_req_valid_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                mem_we_q, mem_we_d;
    logic [XLEN-1:0]     mem_wdata_q, mem_wdata_d;
    logic [NB-1:0]       mem_wmask_q, mem_wmask_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [XLEN-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;

    logic                fault_c;
    logic [ADDR_W-1:0]   mem_addr_c;
    logic [XLEN-1:0]     mem_wdata_c;
    logic [NB-1:0]       mem_wmask_c;
    logic [XLEN-1:0]     ld_data_c;

    ysyx_24100005_lsu_align #(
        .XLEN   (XLEN),
        .ADDR_W (ADDR_W)
    ) u_align (
        .req_we_i     (req_we),
        .req_funct3_i (req_funct3),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .fault_c      (fault_c),
        .mem_addr_c   (mem_addr_c),
        .mem_wdata_c  (mem_wdata_c),
        .mem_wmask_c  (mem_wmask_c),
        .ld_funct3_i  (funct3_q),
        .ld_off_i     (off_q),
        .ld_rdata_i   (mem_rdata),
        .ld_data_c    (ld_data_c)
    );

    assign req_ready     = req_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_err       = rsp_err_q;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_addr      = mem_addr_q;
    assign mem_we        = mem_we_q;
    assign mem_wdata     = mem_wdata_q;
    assign mem_wmask     = mem_wmask_q;

    // Next state and next registered outputs; outputs idle at zero unless a state drives them.
    always_comb begin
        state_d         = state_q;
        we_d            = we_q;
        funct3_d        = funct3_q;
        off_d           = off_q;
        req_ready_d     = 1'b0;
        mem_req_valid_d = 1'b0;
        mem_addr_d      = '0;
        mem_we_d        = 1'b0;
        mem_wdata_d     = '0;
        mem_wmask_d     = '0;
        rsp_valid_d     = 1'b0;
        rsp_rdata_d     = '0;
        rsp_err_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    off_d    = req_addr[OFF_W-1:0];
                    if (fault_c) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d         = ST_MREQ;
                        mem_req_valid_d = 1'b1;
                        mem_addr_d      = mem_addr_c;
                        mem_we_d        = req_we;
                        mem_wdata_d     = req_we ? mem_wdata_c : '0;
                        mem_wmask_d     = req_we ? mem_wmask_c : '0;
                    end
                end else begin
                    req_ready_d = 1'b1;
                end
            end
            ST_MREQ: begin
                if (mem_req_ready) begin
                    state_d = ST_MWAIT;
                end else begin
                    mem_req_valid_d = 1'b1;
                    mem_addr_d      = mem_addr_q;
                    mem_we_d        = mem_we_q;
                    mem_wdata_d     = mem_wdata_q;
                    mem_wmask_d     = mem_wmask_q;
                end
            end
            ST_MWAIT: begin
                if (mem_rsp_valid) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = we_q ? '0 : ld_data_c;
                end
            end
            ST_RESP: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, captured request fields and output registers; reset aborts any access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= ST_IDLE;
            we_q            <= 1'b0;
            funct3_q        <= 3'd0;
            off_q           <= '0;
            req_ready_q     <= 1'b1;
            mem_req_valid_q <= 1'b0;
            mem_addr_q      <= '0;
            mem_we_q        <= 1'b0;
            mem_wdata_q     <= '0;
            mem_wmask_q     <= '0;
            rsp_valid_q     <= 1'b0;
            rsp_rdata_q     <= '0;
            rsp_err_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            we_q            <= we_d;
            funct3_q        <= funct3_d;
            off_q           <= off_d;
            req_ready_q     <= req_ready_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_addr_q      <= mem_addr_d;
            mem_we_q        <= mem_we_d;
            mem_wdata_q     <= mem_wdata_d;
            mem_wmask_q     <= mem_wmask_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_rdata_q     <= rsp_rdata_d;
            rsp_err_q       <= rsp_err_d;
        end
    end

endmodule

// File: doc/ysyx_24100005_lsu.md
YSYX_24100005_LSU -- requirements
Module: ysyx_24100005_lsu

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the data width; legal values are 32 and 64.
REQ-002 Parameter ADDR_W, default 32, SHALL set the address width.
REQ-003 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-low (0 = reset asserted).
REQ-005 req_valid  in  1 / req_ready  out  1  core request handshake; transfer occurs when both are high.
REQ-006 req_we  in  1 (1 = store) / req_funct3  in  3 (RISC-V load/store funct3) / req_addr  in  ADDR_W / req_wdata  in  XLEN.
REQ-007 rsp_valid  out  1  one-cycle completion pulse / rsp_rdata  out  XLEN  extended load data / rsp_err  out  1  access fault.
REQ-008 mem_req_valid  out  1 / mem_req_ready  in  1  memory request handshake.
REQ-009 mem_addr  out  ADDR_W  XLEN/8-aligned / mem_we  out  1 / mem_wdata  out  XLEN  lane-shifted / mem_wmask  out  XLEN/8  byte enables.
REQ-010 mem_rsp_valid  in  1  memory read data or write acknowledge / mem_rdata  in  XLEN  full aligned word.

Function
REQ-011 FSM states SHALL be IDLE, MREQ, MWAIT, RESP.
REQ-012 req_ready SHALL be 1 only in IDLE; on a handshake all request fields SHALL be captured and the FSM SHALL enter MREQ, or RESP with rsp_err=1 if the access is illegal.
REQ-013 In MREQ, mem_req_valid SHALL be 1 and mem_* fields SHALL stay stable until mem_req_ready=1; the FSM then SHALL enter MWAIT.
REQ-014 In MWAIT, mem_rsp_valid=1 SHALL capture mem_rdata (loads) and move to RESP; mem_rsp_valid outside MWAIT SHALL be ignored.
REQ-015 RESP SHALL assert rsp_valid for exactly one cycle and then return to IDLE; there is no response back-pressure.
REQ-016 Minimum latency: handshake in cycle N, mem_req_valid in N+1, rsp_valid in N+3 when mem_req_ready=1 in N+1 and mem_rsp_valid=1 in N+2.
REQ-017 off = addr[log2(XLEN/8)-1:0]; mem_addr SHALL be addr with off cleared.
REQ-018 Loads: data = mem_rdata >> (8*off); LB/LH/LW SHALL sign-extend to XLEN; LBU/LHU/LWU SHALL zero-extend; LD SHALL pass through.
REQ-019 Stores: mem_wmask = ((1<<size)-1) << off, truncated to XLEN/8 bits; mem_wdata = req_wdata << (8*off).
REQ-020 Legal funct3: loads 0,1,2,4,5, plus 3 (LD) and 6 (LWU) when XLEN=64; stores 0,1,2, plus 3 (SD) when XLEN=64; any other value SHALL raise rsp_err with no memory transaction.
REQ-021 On a store, or whenever rsp_err=1, rsp_rdata SHALL be 0.
REQ-022 mem_we, mem_wmask and mem_wdata SHALL be 0 outside MREQ.

Reset
REQ-023 Reset assertion SHALL force IDLE immediately, in any state, including mid-transaction.
REQ-024 Under reset all outputs SHALL be 0 except req_ready; req_ready SHALL be 1 in the first cycle after reset release.
REQ-025 A memory response that arrives after reset aborts an access SHALL be discarded.

Configuration
REQ-026 Macro YSYX_24100005_LSU_MISALIGN_EN defined: an access with off not a multiple of its size SHALL issue no memory request and SHALL produce rsp_valid with rsp_err=1 one cycle after the handshake.
REQ-027 Macro undefined: misaligned accesses SHALL be issued as per REQ-017..019; bytes beyond the aligned word are dropped and rsp_err is never set for misalignment.

Structure
REQ-028 Package ysyx_24100005_pkg SHALL hold the funct3 load/store constants, the FSM state typedef and the size-decode function.
REQ-029 Sub-module ysyx_24100005_lsu_align SHALL hold the combinational lane shift, extension and mask generation; the parent holds the FSM and registers.

Verification
REQ-030 LB at 0x8000_0003, mem_rdata=0x80AB_CDEF -> mem_addr=0x8000_0000, rsp_rdata=0xFFFF_FF80, rsp_err=0.
REQ-031 SH at 0x8000_0002, wdata=0x0000_1234 -> mem_wmask=4'b1100, mem_wdata=0x1234_0000, rsp_rdata=0.
REQ-032 LW at 0x8000_0002: with macro -> no mem_req_valid, rsp_err=1 in N+1; without macro -> mem_addr=0x8000_0000, rsp_err=0.
REQ-033 mem_req_ready held 0 for 5 cycles -> mem_* stable, req_ready=0 throughout, rsp_valid in N+8.
REQ-034 Reset asserted in MWAIT, then mem_rsp_valid pulsed -> outputs 0 immediately, rsp_valid stays 0, req_ready=1 after release.
REQ-035 XLEN=64, LWU at 0x...04, mem_rdata=0xF000_0001_xxxx_xxxx -> rsp_rdata=0x0000_0000_F000_0001; funct3=7 load -> rsp_err=1.
